// File: rtl/router_pkt_tx.sv
// router_pkt_tx: buffered source-side packet transmitter feeding the 1x3 router input port.
// Optional feature macro PARITY_INJECT_EN adds inject_err to send an inverted parity byte.
module router_pkt_tx #(
   parameter  int unsigned DATA_W = 8,
   parameter  int unsigned LEN_W  = 6,
   parameter  int unsigned DEPTH  = 64,
   localparam int unsigned CNT_W  = $clog2(DEPTH + 1)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              pay_wr,
   input  logic [DATA_W-1:0] pay_din,
   output logic              buf_full,
   output logic [CNT_W-1:0]  buf_count,
   input  logic              start,
   input  logic [1:0]        dest_addr,
   input  logic [LEN_W-1:0]  pay_len,
`ifdef PARITY_INJECT_EN
   input  logic              inject_err,
`endif
   input  logic              busy,
   output logic              pkt_valid,
   output logic [DATA_W-1:0] data_out,
   output logic              tx_active,
   output logic              done,
   output logic              start_err
);

   localparam int unsigned PTR_W = $clog2(DEPTH);

   typedef enum logic [2:0] {
      S_IDLE,
      S_HEADER,
      S_PAYLOAD,
      S_PARITY,
      S_DONE
   } state_t;

   state_t              state_q, state_d;
   logic [DATA_W-1:0]   mem_q [DEPTH];
   logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
   logic [CNT_W-1:0]    count_q, count_d;
   logic                full_q;
   logic [LEN_W-1:0]    rem_q, rem_d;
   logic [DATA_W-1:0]   parity_q, parity_d;
   logic [DATA_W-1:0]   data_q, data_d;
   logic                pkt_valid_q, pkt_valid_d;
   logic                tx_active_q, tx_active_d;
   logic                done_q, done_d;
   logic                start_err_q, start_err_d;
   logic                inject_q, inject_d;

   logic                push_c, pop_c, start_ok_c;
   logic [DATA_W-1:0]   head_c, head_nxt_c, par_fin_c, hdr_c;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : PTR_W'(p + 1'b1);
   endfunction

   assign push_c     = pay_wr && !full_q;
   assign head_c     = mem_q[rd_ptr_q];
   assign head_nxt_c = mem_q[ptr_inc(rd_ptr_q)];
   assign hdr_c      = DATA_W'({pay_len, dest_addr});
   assign start_ok_c = (pay_len != '0) && (dest_addr != 2'd3) &&
                       (count_q >= CNT_W'(pay_len));

`ifdef PARITY_INJECT_EN
   assign inject_d  = (state_q == S_IDLE && start && start_ok_c) ? inject_err : inject_q;
   assign par_fin_c = inject_q ? ~(parity_q ^ data_q) : (parity_q ^ data_q);
`else
   assign inject_d  = 1'b0;
   assign par_fin_c = parity_q ^ data_q;
`endif

   // Next-state and registered-output values; every byte update happens on a transfer.
   always_comb begin
      state_d     = state_q;
      rem_d       = rem_q;
      parity_d    = parity_q;
      data_d      = data_q;
      pkt_valid_d = pkt_valid_q;
      tx_active_d = tx_active_q;
      done_d      = 1'b0;
      start_err_d = 1'b0;
      pop_c       = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               if (start_ok_c) begin
                  state_d     = S_HEADER;
                  rem_d       = pay_len;
                  data_d      = hdr_c;
                  pkt_valid_d = 1'b1;
                  tx_active_d = 1'b1;
               end else begin
                  start_err_d = 1'b1;
               end
            end
         end
         S_HEADER: begin
            if (!busy) begin
               parity_d = data_q;
               data_d   = head_c;
               state_d  = S_PAYLOAD;
            end
         end
         S_PAYLOAD: begin
            if (!busy) begin
               pop_c    = 1'b1;
               parity_d = parity_q ^ data_q;
               rem_d    = LEN_W'(rem_q - 1'b1);
               if (rem_q == LEN_W'(1)) begin
                  data_d      = par_fin_c;
                  pkt_valid_d = 1'b0;
                  state_d     = S_PARITY;
               end else begin
                  data_d = head_nxt_c;
               end
            end
         end
         S_PARITY: begin
            if (!busy) begin
               data_d      = '0;
               tx_active_d = 1'b0;
               done_d      = 1'b1;
               state_d     = S_DONE;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d     = S_IDLE;
            data_d      = '0;
            pkt_valid_d = 1'b0;
            tx_active_d = 1'b0;
         end
      endcase
   end

   always_comb begin
      count_d = count_q;
      case ({push_c, pop_c})
         2'b10:   count_d = CNT_W'(count_q + 1'b1);
         2'b01:   count_d = CNT_W'(count_q - 1'b1);
         default: count_d = count_q;
      endcase
   end

   // Storage has no reset; emptiness is defined by the pointers and count.
   always_ff @(posedge clk) begin
      if (push_c) begin
         mem_q[wr_ptr_q] <= pay_din;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         full_q      <= 1'b0;
         rem_q       <= '0;
         parity_q    <= '0;
         data_q      <= '0;
         pkt_valid_q <= 1'b0;
         tx_active_q <= 1'b0;
         done_q      <= 1'b0;
         start_err_q <= 1'b0;
         inject_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         if (push_c) wr_ptr_q <= ptr_inc(wr_ptr_q);
         if (pop_c)  rd_ptr_q <= ptr_inc(rd_ptr_q);
         count_q     <= count_d;
         full_q      <= (count_d == CNT_W'(DEPTH));
         rem_q       <= rem_d;
         parity_q    <= parity_d;
         data_q      <= data_d;
         pkt_valid_q <= pkt_valid_d;
         tx_active_q <= tx_active_d;
         done_q      <= done_d;
         start_err_q <= start_err_d;
         inject_q    <= inject_d;
      end
   end

   assign buf_full  = full_q;
   assign buf_count = count_q;
   assign pkt_valid = pkt_valid_q;
   assign data_out  = data_q;
   assign tx_active = tx_active_q;
   assign done      = done_q;
   assign start_err = start_err_q;

endmodule

// File: tb/tb_router_pkt_tx.sv
// tb_router_pkt_tx: directed self-checking bench for router_pkt_tx.
// Inputs change 1 ns after posedge; outputs are sampled at the same point.
module tb_router_pkt_tx;

   logic       clk = 1'b0;
   logic       rst;
   logic       pay_wr;
   logic [7:0] pay_din;
   logic       buf_full;
   logic [6:0] buf_count;
   logic       start;
   logic [1:0] dest_addr;
   logic [5:0] pay_len;
`ifdef PARITY_INJECT_EN
   logic       inject_err;
`endif
   logic       busy;
   logic       pkt_valid;
   logic [7:0] data_out;
   logic       tx_active;
   logic       done;
   logic       start_err;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   router_pkt_tx dut (
      .clk       (clk),
      .rst       (rst),
      .pay_wr    (pay_wr),
      .pay_din   (pay_din),
      .buf_full  (buf_full),
      .buf_count (buf_count),
      .start     (start),
      .dest_addr (dest_addr),
      .pay_len   (pay_len),
`ifdef PARITY_INJECT_EN
      .inject_err(inject_err),
`endif
      .busy      (busy),
      .pkt_valid (pkt_valid),
      .data_out  (data_out),
      .tx_active (tx_active),
      .done      (done),
      .start_err (start_err)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr_byte(input logic [7:0] v);
      pay_wr  = 1'b1;
      pay_din = v;
      tick();
      pay_wr  = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      checks += 7;
      if (pkt_valid !== 1'b0) begin errors++; $display("FAIL reset_pkt_valid got %h exp 0", pkt_valid); end
      if (data_out  !== 8'h00) begin errors++; $display("FAIL reset_data_out got %h exp 00", data_out); end
      if (tx_active !== 1'b0) begin errors++; $display("FAIL reset_tx_active got %h exp 0", tx_active); end
      if (done      !== 1'b0) begin errors++; $display("FAIL reset_done got %h exp 0", done); end
      if (start_err !== 1'b0) begin errors++; $display("FAIL reset_start_err got %h exp 0", start_err); end
      if (buf_count !== 7'd0) begin errors++; $display("FAIL reset_buf_count got %0d exp 0", buf_count); end
      if (buf_full  !== 1'b0) begin errors++; $display("FAIL reset_buf_full got %h exp 0", buf_full); end
      rst = 1'b0;
      tick();
   endtask

   task automatic test_basic();
      logic [7:0] b [6] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
      logic [7:0] par = 8'h18;
      for (int i = 0; i < 6; i++) begin wr_byte(b[i]); par ^= b[i]; end
      checks++;
      if (buf_count !== 7'd6) begin errors++; $display("FAIL basic_count got %0d exp 6", buf_count); end
      dest_addr = 2'd0; pay_len = 6'd6; start = 1'b1;
      tick();
      start = 1'b0;
      checks += 3;
      if (data_out !== 8'h18) begin errors++; $display("FAIL basic_header got %h exp 18", data_out); end
      if (pkt_valid !== 1'b1) begin errors++; $display("FAIL basic_hdr_valid got %h exp 1", pkt_valid); end
      if (tx_active !== 1'b1) begin errors++; $display("FAIL basic_tx_active got %h exp 1", tx_active); end
      for (int i = 0; i < 6; i++) begin
         tick();
         checks += 2;
         if (data_out !== b[i]) begin errors++; $display("FAIL basic_byte%0d got %h exp %h", i, data_out, b[i]); end
         if (pkt_valid !== 1'b1) begin errors++; $display("FAIL basic_valid%0d got %h exp 1", i, pkt_valid); end
      end
      tick();
      checks += 3;
      if (data_out !== par) begin errors++; $display("FAIL basic_parity got %h exp %h", data_out, par); end
      if (pkt_valid !== 1'b0) begin errors++; $display("FAIL basic_par_valid got %h exp 0", pkt_valid); end
      if (done !== 1'b0) begin errors++; $display("FAIL basic_done_early got %h exp 0", done); end
      tick();
      checks += 3;
      if (done !== 1'b1) begin errors++; $display("FAIL basic_done got %h exp 1", done); end
      if (tx_active !== 1'b0) begin errors++; $display("FAIL basic_done_active got %h exp 0", tx_active); end
      if (buf_count !== 7'd0) begin errors++; $display("FAIL basic_count_end got %0d exp 0", buf_count); end
      tick();
      checks++;
      if (done !== 1'b0) begin errors++; $display("FAIL basic_done_pulse got %h exp 0", done); end
   endtask

   task automatic test_busy();
      logic [7:0] b [6] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
      logic [7:0] par = 8'h18;
      for (int i = 0; i < 6; i++) begin wr_byte(b[i]); par ^= b[i]; end
      dest_addr = 2'd0; pay_len = 6'd6; start = 1'b1;
      tick();
      start = 1'b0;
      busy  = 1'b1;
      for (int k = 0; k < 3; k++) begin
         tick();
         checks += 2;
         if (data_out !== 8'h18) begin errors++; $display("FAIL busy_hdr_hold%0d got %h exp 18", k, data_out); end
         if (pkt_valid !== 1'b1) begin errors++; $display("FAIL busy_hdr_valid%0d got %h exp 1", k, pkt_valid); end
      end
      busy = 1'b0;
      for (int i = 0; i < 6; i++) begin
         tick();
         checks += 2;
         if (data_out !== b[i]) begin errors++; $display("FAIL busy_byte%0d got %h exp %h", i, data_out, b[i]); end
         if (pkt_valid !== 1'b1) begin errors++; $display("FAIL busy_valid%0d got %h exp 1", i, pkt_valid); end
         if (i == 3) begin
            busy = 1'b1;
            for (int k = 0; k < 2; k++) begin
               tick();
               checks += 2;
               if (data_out !== 8'h44) begin errors++; $display("FAIL busy_b4_hold%0d got %h exp 44", k, data_out); end
               if (pkt_valid !== 1'b1) begin errors++; $display("FAIL busy_b4_valid%0d got %h exp 1", k, pkt_valid); end
            end
            busy = 1'b0;
         end
      end
      tick();
      checks += 2;
      if (data_out !== par) begin errors++; $display("FAIL busy_parity got %h exp %h", data_out, par); end
      if (done !== 1'b0) begin errors++; $display("FAIL busy_done_early got %h exp 0", done); end
      tick();
      checks++;
      if (done !== 1'b1) begin errors++; $display("FAIL busy_done got %h exp 1", done); end
      tick();
   endtask

   task automatic test_start_err();
      logic [7:0] b [3] = '{8'hA1, 8'hA2, 8'hA3};
      logic [1:0] ea [3] = '{2'd0, 2'd1, 2'd3};
      logic [5:0] el [3] = '{6'd5, 6'd0, 6'd1};
      logic [7:0] par = 8'h0E;
      for (int i = 0; i < 3; i++) begin wr_byte(b[i]); par ^= b[i]; end
      for (int k = 0; k < 3; k++) begin
         dest_addr = ea[k]; pay_len = el[k]; start = 1'b1;
         tick();
         start = 1'b0;
         checks += 3;
         if (start_err !== 1'b1) begin errors++; $display("FAIL err_pulse%0d got %h exp 1", k, start_err); end
         if (pkt_valid !== 1'b0) begin errors++; $display("FAIL err_valid%0d got %h exp 0", k, pkt_valid); end
         if (tx_active !== 1'b0) begin errors++; $display("FAIL err_active%0d got %h exp 0", k, tx_active); end
         tick();
         checks += 2;
         if (start_err !== 1'b0) begin errors++; $display("FAIL err_clear%0d got %h exp 0", k, start_err); end
         if (buf_count !== 7'd3) begin errors++; $display("FAIL err_count%0d got %0d exp 3", k, buf_count); end
      end
      dest_addr = 2'd2; pay_len = 6'd3; start = 1'b1;
      tick();
      start = 1'b0;
      checks++;
      if (data_out !== 8'h0E) begin errors++; $display("FAIL err_pkt_header got %h exp 0e", data_out); end
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++;
         if (data_out !== b[i]) begin errors++; $display("FAIL err_pkt_byte%0d got %h exp %h", i, data_out, b[i]); end
      end
      tick();
      checks++;
      if (data_out !== par) begin errors++; $display("FAIL err_pkt_parity got %h exp %h", data_out, par); end
      tick();
      tick();
   endtask

   task automatic test_full_wrap();
      logic [7:0] par = 8'hFD;
      logic [7:0] e;
      logic [7:0] nb [11];
      for (int i = 0; i < 64; i++) wr_byte(8'(i * 3 + 1));
      checks += 2;
      if (buf_full !== 1'b1) begin errors++; $display("FAIL full_flag got %h exp 1", buf_full); end
      if (buf_count !== 7'd64) begin errors++; $display("FAIL full_count got %0d exp 64", buf_count); end
      wr_byte(8'hFF);
      checks += 2;
      if (buf_full !== 1'b1) begin errors++; $display("FAIL full_flag_drop got %h exp 1", buf_full); end
      if (buf_count !== 7'd64) begin errors++; $display("FAIL full_count_drop got %0d exp 64", buf_count); end
      dest_addr = 2'd1; pay_len = 6'd63; start = 1'b1;
      tick();
      start = 1'b0;
      checks++;
      if (data_out !== 8'hFD) begin errors++; $display("FAIL wrap_header got %h exp fd", data_out); end
      for (int i = 0; i < 63; i++) begin
         pay_wr  = (i >= 2 && i < 12);
         pay_din = 8'(8'h80 + i);
         tick();
         e = 8'(i * 3 + 1);
         par ^= e;
         checks += 2;
         if (data_out !== e) begin errors++; $display("FAIL wrap_byte%0d got %h exp %h", i, data_out, e); end
         if (pkt_valid !== 1'b1) begin errors++; $display("FAIL wrap_valid%0d got %h exp 1", i, pkt_valid); end
      end
      pay_wr = 1'b0;
      tick();
      checks++;
      if (data_out !== par) begin errors++; $display("FAIL wrap_parity got %h exp %h", data_out, par); end
      tick();
      checks += 3;
      if (done !== 1'b1) begin errors++; $display("FAIL wrap_done got %h exp 1", done); end
      if (buf_count !== 7'd11) begin errors++; $display("FAIL wrap_count got %0d exp 11", buf_count); end
      if (buf_full !== 1'b0) begin errors++; $display("FAIL wrap_full got %h exp 0", buf_full); end
      tick();
      nb[0] = 8'hBE;
      for (int i = 1; i < 11; i++) nb[i] = 8'(8'h81 + i);
      dest_addr = 2'd2; pay_len = 6'd11; start = 1'b1;
      tick();
      start = 1'b0;
      par = 8'h2E;
      checks++;
      if (data_out !== 8'h2E) begin errors++; $display("FAIL wrap2_header got %h exp 2e", data_out); end
      for (int i = 0; i < 11; i++) begin
         tick();
         par ^= nb[i];
         checks++;
         if (data_out !== nb[i]) begin errors++; $display("FAIL wrap2_byte%0d got %h exp %h", i, data_out, nb[i]); end
      end
      tick();
      checks++;
      if (data_out !== par) begin errors++; $display("FAIL wrap2_parity got %h exp %h", data_out, par); end
      tick();
      tick();
      checks++;
      if (buf_count !== 7'd0) begin errors++; $display("FAIL wrap2_count got %0d exp 0", buf_count); end
   endtask

   task automatic test_reset_mid();
      for (int i = 0; i < 5; i++) wr_byte(8'(8'h30 + i));
      dest_addr = 2'd0; pay_len = 6'd5; start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      tick();
      tick();
      checks++;
      if (data_out !== 8'h32) begin errors++; $display("FAIL mid_byte3 got %h exp 32", data_out); end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checks += 4;
      if (pkt_valid !== 1'b0) begin errors++; $display("FAIL mid_valid got %h exp 0", pkt_valid); end
      if (buf_count !== 7'd0) begin errors++; $display("FAIL mid_count got %0d exp 0", buf_count); end
      if (tx_active !== 1'b0) begin errors++; $display("FAIL mid_active got %h exp 0", tx_active); end
      if (data_out !== 8'h00) begin errors++; $display("FAIL mid_data got %h exp 00", data_out); end
      dest_addr = 2'd0; pay_len = 6'd1; start = 1'b1;
      tick();
      start = 1'b0;
      checks++;
      if (start_err !== 1'b1) begin errors++; $display("FAIL mid_idle_err got %h exp 1", start_err); end
      tick();
   endtask

   task automatic test_parity_byte();
      wr_byte(8'hA5);
`ifdef PARITY_INJECT_EN
      inject_err = 1'b1;
`endif
      dest_addr = 2'd1; pay_len = 6'd1; start = 1'b1;
      tick();
      start = 1'b0;
`ifdef PARITY_INJECT_EN
      inject_err = 1'b0;
`endif
      checks++;
      if (data_out !== 8'h05) begin errors++; $display("FAIL par_header got %h exp 05", data_out); end
      tick();
      checks++;
      if (data_out !== 8'hA5) begin errors++; $display("FAIL par_byte got %h exp a5", data_out); end
      tick();
      checks += 2;
`ifdef PARITY_INJECT_EN
      if (data_out !== 8'h5F) begin errors++; $display("FAIL par_inject got %h exp 5f", data_out); end
`else
      if (data_out !== 8'hA0) begin errors++; $display("FAIL par_clean got %h exp a0", data_out); end
`endif
      if (pkt_valid !== 1'b0) begin errors++; $display("FAIL par_valid got %h exp 0", pkt_valid); end
      tick();
      checks++;
      if (done !== 1'b1) begin errors++; $display("FAIL par_done got %h exp 1", done); end
      tick();
   endtask

   initial begin
      rst = 1'b1; pay_wr = 1'b0; pay_din = '0; start = 1'b0;
      dest_addr = '0; pay_len = '0; busy = 1'b0;
`ifdef PARITY_INJECT_EN
      inject_err = 1'b0;
`endif
      test_reset();
      test_basic();
      test_busy();
      test_start_err();
      test_full_wrap();
      test_reset_mid();
      test_parity_byte();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired got running exp finished");
      $fatal(1, "watchdog");
   end

endmodule
